mac_tx_sched: RTL and testbench

- Round-robin scheduler that shares the single UDP TX path between up to NDEV ADC device FIFOs.
- Counts samples pending per device. When a device reaches fifo2mac_num samples, it issues one packet request to the UDP TX engine using the fs_/fd_ level handshake.
- Sits between the ADC read/FIFO stage and the UDP TX engine. It is enabled by the command/state controller once the main state reaches work.

---
 rtl/mac_tx_sched_if.sv | 31 +++
 rtl/mac_tx_sched.sv | 149 ++++++++++++++
 tb/tb_mac_tx_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_sched_if
// Description : Level handshake bundle between the TX scheduler (master) and
//               the UDP TX engine (slave): request/done levels plus the
//               granted device index and packet length.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_tx_sched_if #(
    parameter int DW = 3
);
    logic          fs_udp_tx;
    logic          fd_udp_tx;
    logic [DW-1:0] tx_dev;
    logic [7:0]    tx_len;

    modport master (
        output fs_udp_tx,
        output tx_dev,
        output tx_len,
        input  fd_udp_tx
    );

    modport slave (
        input  fs_udp_tx,
        input  tx_dev,
        input  tx_len,
        output fd_udp_tx
    );
endinterface
`default_nettype wire

// File: rtl/mac_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_sched
// Description : Round-robin scheduler sharing one UDP TX path between NDEV
//               ADC device FIFOs. Counts pending samples per device and
//               requests one packet when a device holds a full packet.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_sched #(
    parameter int NDEV = 8,
    parameter int DW   = 3,
    parameter int CW   = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            fs_sched,
    input  wire logic [7:0]      fifo2mac_num,
    input  wire logic [NDEV-1:0] dev_mask,
    input  wire logic [NDEV-1:0] smp_rdy,
    mac_tx_sched_if.master       tx_if,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam int          c_CMPW = (CW > 8) ? CW : 8;
    localparam logic [CW-1:0] c_PMAX = {CW{1'b1}};
    localparam logic [DW-1:0] c_LAST = DW'(NDEV - 1);
    localparam logic [DW:0]   c_NDEV = (DW + 1)'(NDEV);

    state_t          state_q, state_d;
    logic [CW-1:0]   pend_q [NDEV];
    logic [DW-1:0]   last_q;
    logic [DW-1:0]   tx_dev_q;
    logic [7:0]      tx_len_q;
    logic            fs_q;
    logic            busy_q;
    logic            err_q;

    logic [7:0]      w_n;
    logic [NDEV-1:0] w_ge;
    logic [NDEV-1:0] w_ovf;
    logic            w_hit;
    logic [DW-1:0]   w_hit_idx;
    logic [DW:0]     w_idx;
    logic            w_done;

    // Zero-length request from the controller means single-sample packets.
    assign w_n    = (fifo2mac_num == 8'd0) ? 8'd1 : fifo2mac_num;
    assign w_done = (state_q == SEND) && tx_if.fd_udp_tx;

    assign tx_if.fs_udp_tx = fs_q;
    assign tx_if.tx_dev    = tx_dev_q;
    assign tx_if.tx_len    = tx_len_q;
    assign busy            = busy_q;
    assign err             = err_q;

    // Round-robin search starting just after the last granted device.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_idx     = '0;
        for (int k = 1; k <= NDEV; k++) begin
            w_idx = {1'b0, last_q} + (DW + 1)'(k);
            if (w_idx >= c_NDEV) begin
                w_idx = w_idx - c_NDEV;
            end
            if (!w_hit && dev_mask[w_idx[DW-1:0]] && w_ge[w_idx[DW-1:0]]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_idx[DW-1:0];
            end
        end
    end

    // Next-state logic for the scan / request / release handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fs_sched) state_d = SCAN;
            SCAN: begin
                if (!fs_sched) begin
                    state_d = IDLE;
                end else if (w_hit) begin
                    state_d = SEND;
                end
            end
            SEND: if (tx_if.fd_udp_tx) state_d = REL;
            REL:  if (!tx_if.fd_udp_tx) state_d = fs_sched ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= c_LAST;
            tx_dev_q <= '0;
            tx_len_q <= '0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fs_q    <= (state_d == SEND);
            busy_q  <= (state_d == SEND) || (state_d == REL);
            err_q   <= err_q | (|w_ovf);
            if ((state_q == SCAN) && (state_d == SEND)) begin
                tx_dev_q <= w_hit_idx;
                tx_len_q <= w_n;
                last_q   <= w_hit_idx;
            end
        end
    end

    generate
        for (genvar i = 0; i < NDEV; i++) begin : g_pend
            logic w_inc;
            logic w_sub;

            assign w_inc    = smp_rdy[i] && dev_mask[i] && (state_q != IDLE);
            assign w_sub    = w_done && (tx_dev_q == DW'(i));
            assign w_ge[i]  = (c_CMPW'(pend_q[i]) >= c_CMPW'(w_n));
            // Saturation only matters when no packet is being drained this cycle.
            assign w_ovf[i] = w_inc && !w_sub && (pend_q[i] == c_PMAX);

            // Per-device pending counter: count, drain on done, clear on IDLE.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q[i] <= '0;
                end else if (state_d == IDLE) begin
                    pend_q[i] <= '0;
                end else if (w_sub) begin
                    pend_q[i] <= pend_q[i] - CW'(tx_len_q) + CW'(w_inc);
                end else if (w_inc && (pend_q[i] != c_PMAX)) begin
                    pend_q[i] <= pend_q[i] + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tx_sched
// Description : Directed self-checking bench for the round-robin TX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tx_sched;

    logic       clk;
    logic       rst_n;
    logic       fs_sched;
    logic [7:0] fifo2mac_num;
    logic [7:0] dev_mask;
    logic [7:0] smp_rdy;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    mac_tx_sched_if #(.DW(3)) tx_if ();

    mac_tx_sched #(.NDEV(8), .DW(3), .CW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fs_sched     (fs_sched),
        .fifo2mac_num (fifo2mac_num),
        .dev_mask     (dev_mask),
        .smp_rdy      (smp_rdy),
        .tx_if        (tx_if),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        fs_sched        = 1'b0;
        fifo2mac_num    = 8'd1;
        dev_mask        = 8'h00;
        smp_rdy         = 8'h00;
        tx_if.fd_udp_tx = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse(input logic [7:0] m);
        smp_rdy = m;
        tick();
        smp_rdy = 8'h00;
    endtask

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (tx_if.fs_udp_tx === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic release_tx();
        tx_if.fd_udp_tx = 1'b1;
        tick();
        tx_if.fd_udp_tx = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx_if.fs_udp_tx !== 1'b0 || tx_if.tx_dev !== 3'd0 || tx_if.tx_len !== 8'd0 ||
            busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got fs=%b dev=%0d len=%0d busy=%b err=%b required 0 0 0 0 0",
                     tx_if.fs_udp_tx, tx_if.tx_dev, tx_if.tx_len, busy, err);
        end
        checks++;
        if (dut.last_q !== 3'd7 || dut.pend_q[0] !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got last=%0d pend0=%0d required 7 0", dut.last_q, dut.pend_q[0]);
        end
    endtask

    task automatic test_single();
        logic ok;
        do_reset();
        dev_mask = 8'h01; fifo2mac_num = 8'd4; fs_sched = 1'b1;
        tick();
        repeat (4) pulse(8'h01);
        checks++;
        if (tx_if.fs_udp_tx !== 1'b0 || dut.pend_q[0] !== 8'd4) begin
            errors++;
            $display("FAIL single_pre: got fs=%b pend0=%0d required 0 4", tx_if.fs_udp_tx, dut.pend_q[0]);
        end
        tick();
        checks++;
        if (tx_if.fs_udp_tx !== 1'b1 || tx_if.tx_dev !== 3'd0 || tx_if.tx_len !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got fs=%b dev=%0d len=%0d busy=%b required 1 0 4 1",
                     tx_if.fs_udp_tx, tx_if.tx_dev, tx_if.tx_len, busy);
        end
        tx_if.fd_udp_tx = 1'b1;
        tick();
        checks++;
        if (tx_if.fs_udp_tx !== 1'b0 || dut.pend_q[0] !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got fs=%b pend0=%0d busy=%b required 0 0 1",
                     tx_if.fs_udp_tx, dut.pend_q[0], busy);
        end
        tx_if.fd_udp_tx = 1'b0;
        tick();
        wait_grant(ok);
        checks++;
        if (busy !== 1'b0 || ok !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b regrant=%b required 0 0", busy, ok);
        end
    endtask

    task automatic test_round_robin();
        logic       ok;
        logic [2:0] exp_dev [5];
        exp_dev = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd2};
        do_reset();
        dev_mask = 8'h07; fifo2mac_num = 8'd2; fs_sched = 1'b1;
        tick();
        repeat (2) pulse(8'h07);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) repeat (2) pulse(8'h05);
            wait_grant(ok);
            checks++;
            if (ok !== 1'b1 || tx_if.tx_dev !== exp_dev[k] || tx_if.tx_len !== 8'd2) begin
                errors++;
                $display("FAIL rr_grant%0d: got ok=%b dev=%0d len=%0d required 1 %0d 2",
                         k, ok, tx_if.tx_dev, tx_if.tx_len, exp_dev[k]);
            end
            release_tx();
        end
        checks++;
        if (dut.pend_q[0] !== 8'd0 || dut.pend_q[1] !== 8'd0 || dut.pend_q[2] !== 8'd0) begin
            errors++;
            $display("FAIL rr_drained: got pend=%0d %0d %0d required 0 0 0",
                     dut.pend_q[0], dut.pend_q[1], dut.pend_q[2]);
        end
    endtask

    task automatic test_simultaneous();
        logic ok;
        do_reset();
        dev_mask = 8'h02; fifo2mac_num = 8'd3; fs_sched = 1'b1;
        tick();
        repeat (3) pulse(8'h02);
        wait_grant(ok);
        checks++;
        if (ok !== 1'b1 || tx_if.tx_dev !== 3'd1) begin
            errors++;
            $display("FAIL simul_grant: got ok=%b dev=%0d required 1 1", ok, tx_if.tx_dev);
        end
        tx_if.fd_udp_tx = 1'b1; smp_rdy = 8'h02;
        tick();
        smp_rdy = 8'h00;
        checks++;
        if (dut.pend_q[1] !== 8'd1 || tx_if.fs_udp_tx !== 1'b0) begin
            errors++;
            $display("FAIL simul_pend: got pend1=%0d fs=%b required 1 0", dut.pend_q[1], tx_if.fs_udp_tx);
        end
        tx_if.fd_udp_tx = 1'b0;
        tick();
    endtask

    task automatic test_zero_len();
        logic ok;
        do_reset();
        dev_mask = 8'h08; fifo2mac_num = 8'd0; fs_sched = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            pulse(8'h08);
            wait_grant(ok);
            checks++;
            if (ok !== 1'b1 || tx_if.tx_dev !== 3'd3 || tx_if.tx_len !== 8'd1) begin
                errors++;
                $display("FAIL zero_len%0d: got ok=%b dev=%0d len=%0d required 1 3 1",
                         k, ok, tx_if.tx_dev, tx_if.tx_len);
            end
            release_tx();
            checks++;
            if (dut.pend_q[3] !== 8'd0) begin
                errors++;
                $display("FAIL zero_len_pend%0d: got %0d required 0", k, dut.pend_q[3]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        dev_mask = 8'h01; fifo2mac_num = 8'd255; fs_sched = 1'b1;
        tick();
        smp_rdy = 8'h01;
        repeat (255) tick();
        smp_rdy = 8'h00;
        checks++;
        if (dut.pend_q[0] !== 8'd255 || err !== 1'b0 || tx_if.fs_udp_tx !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: got pend0=%0d err=%b fs=%b required 255 0 0",
                     dut.pend_q[0], err, tx_if.fs_udp_tx);
        end
        pulse(8'h01);
        checks++;
        if (dut.pend_q[0] !== 8'd255 || err !== 1'b1 || tx_if.fs_udp_tx !== 1'b1 ||
            tx_if.tx_len !== 8'd255) begin
            errors++;
            $display("FAIL ovf_sat: got pend0=%0d err=%b fs=%b len=%0d required 255 1 1 255",
                     dut.pend_q[0], err, tx_if.fs_udp_tx, tx_if.tx_len);
        end
        release_tx();
        checks++;
        if (dut.pend_q[0] !== 8'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got pend0=%0d err=%b required 0 1", dut.pend_q[0], err);
        end
    endtask

    task automatic test_disable();
        logic ok;
        do_reset();
        dev_mask = 8'h01; fifo2mac_num = 8'd1; fs_sched = 1'b1;
        tick();
        pulse(8'h01);
        wait_grant(ok);
        fs_sched = 1'b0;
        tick();
        checks++;
        if (ok !== 1'b1 || tx_if.fs_udp_tx !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dis_hold: got ok=%b fs=%b busy=%b required 1 1 1", ok, tx_if.fs_udp_tx, busy);
        end
        tx_if.fd_udp_tx = 1'b1;
        tick();
        pulse(8'h01);
        checks++;
        if (tx_if.fs_udp_tx !== 1'b0 || busy !== 1'b1 || dut.pend_q[0] !== 8'd1) begin
            errors++;
            $display("FAIL dis_rel: got fs=%b busy=%b pend0=%0d required 0 1 1",
                     tx_if.fs_udp_tx, busy, dut.pend_q[0]);
        end
        tx_if.fd_udp_tx = 1'b0;
        tick();
        pulse(8'h01);
        checks++;
        if (busy !== 1'b0 || dut.pend_q[0] !== 8'd0 || tx_if.fs_udp_tx !== 1'b0) begin
            errors++;
            $display("FAIL dis_idle: got busy=%b pend0=%0d fs=%b required 0 0 0",
                     busy, dut.pend_q[0], tx_if.fs_udp_tx);
        end
    endtask

    task automatic test_async_reset();
        logic ok;
        do_reset();
        dev_mask = 8'h04; fifo2mac_num = 8'd1; fs_sched = 1'b1;
        tick();
        pulse(8'h04);
        wait_grant(ok);
        checks++;
        if (ok !== 1'b1 || tx_if.tx_dev !== 3'd2) begin
            errors++;
            $display("FAIL arst_grant: got ok=%b dev=%0d required 1 2", ok, tx_if.tx_dev);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_if.fs_udp_tx !== 1'b0 || busy !== 1'b0 || tx_if.tx_dev !== 3'd0 ||
            tx_if.tx_len !== 8'd0 || dut.last_q !== 3'd7) begin
            errors++;
            $display("FAIL arst_async: got fs=%b busy=%b dev=%0d len=%0d last=%0d required 0 0 0 0 7",
                     tx_if.fs_udp_tx, busy, tx_if.tx_dev, tx_if.tx_len, dut.last_q);
        end
        tick();
        rst_n = 1'b1;
        fs_sched = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_simultaneous();
        test_zero_len();
        test_overflow();
        test_disable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
